serial_add_seq: RTL

- Bit-serial adder sequencer: one registered full-adder cell, time-shared across the operand bits, LSB first, one bit per clock.
- Trades area for latency: a WIDTH-bit add completes in WIDTH cycles.
- Used where a combinational ripple adder is too large or is not wanted.
- Start/busy/done handshake toward the requesting logic.

---
 rtl/serial_add_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder cell shared across WIDTH bits, LSB first, start/busy/done handshake.
// Optional subtract mode with signed-overflow flag is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       fa_out;

   // Returns {carry_out, sum_bit} of a single full adder.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      logic s;
      logic c;
      s = x ^ y ^ ci;
      c = (x & y) | ((x ^ y) & ci);
      return {c, s};
   endfunction

   assign fa_out = full_add(a_sr[0], b_sr[0], carry);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr <= a;
`ifdef SERIAL_ADD_SUB_EN
                  // Subtraction as a + ~b + 1; cin is not used in this mode.
                  b_sr  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  ovf   <= 1'b0;
`else
                  b_sr  <= b;
                  carry <= cin;
`endif
                  cnt   <= '0;
                  sum   <= '0;
                  cout  <= 1'b0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               sum   <= {fa_out[0], sum[WIDTH-1:1]};
               a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
               carry <= fa_out[1];
               cnt   <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  cout  <= fa_out[1];
`ifdef SERIAL_ADD_SUB_EN
                  // On the MSB cycle, carry holds the carry into the MSB.
                  ovf   <= carry ^ fa_out[1];
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
